// File: rtl/halut_encoder.sv
// halut_encoder: maps per-codebook input subvectors to prototype indices by walking a
// balanced binary decision tree (depth TreeDepth) with per-node FP16 thresholds.
// One pipeline register stage per tree level; one codebook per cycle, no backpressure.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   waddr_i   threshold write address {codebook, node}, node in heap order 0..K-2
//   wdata_i   FP16 threshold value
//   we_i      threshold write enable
//   data_i    split-dimension values; slice l feeds tree level l
//   valid_i   data_i valid this cycle
//   c_addr_o  codebook index of the emitted result
//   k_addr_o  selected leaf (prototype) index
//   valid_o   result valid
module halut_encoder #(
  parameter int unsigned K              = 16,
  parameter int unsigned C              = 32,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned TotalAddrWidth = $clog2(C * K),
  parameter int unsigned CAddrWidth     = $clog2(C),
  parameter int unsigned TreeDepth      = $clog2(K)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [TotalAddrWidth-1:0]          waddr_i,
  input  logic [DataTypeWidth-1:0]           wdata_i,
  input  logic                               we_i,
  input  logic [TreeDepth*DataTypeWidth-1:0] data_i,
  input  logic                               valid_i,
  output logic [CAddrWidth-1:0]              c_addr_o,
  output logic [TreeDepth-1:0]               k_addr_o,
  output logic                               valid_o
);

  localparam int unsigned W     = DataTypeWidth;
  localparam int unsigned Nodes = K - 1;

  // Strict a > b for sign-magnitude floats; +0 and -0 compare equal.
  function automatic logic fp_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-2:0] ma;
    logic [W-2:0] mb;
    logic         res;
    ma = a[W-2:0];
    mb = b[W-2:0];
    if (ma == '0 && mb == '0) begin
      res = 1'b0;
    end else if (a[W-1] != b[W-1]) begin
      res = ~a[W-1];
    end else if (!a[W-1]) begin
      res = (ma > mb);
    end else begin
      res = (ma < mb);
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Threshold storage
  // ---------------------------------------------------------------------------
  logic [W-1:0]            thr_q [C][Nodes];
  logic [CAddrWidth-1:0]   w_c;
  logic [TreeDepth-1:0]    w_n;

  assign w_n = waddr_i[TreeDepth-1:0];
  assign w_c = waddr_i[TreeDepth +: CAddrWidth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < C; c++) begin
        for (int n = 0; n < Nodes; n++) begin
          thr_q[c][n] <= '0;
        end
      end
    end else if (we_i && (w_n != TreeDepth'(Nodes))) begin
      // Node K-1 is the unused slot of each codebook; writes to it are dropped.
      thr_q[w_c][w_n] <= wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Codebook counter
  // ---------------------------------------------------------------------------
  logic [CAddrWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (valid_i) begin
      cnt_d = (cnt_q == CAddrWidth'(C - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-level inputs: level 0 sees the incoming sample, level l sees stage l-1.
  // ---------------------------------------------------------------------------
  logic                  lv_v [TreeDepth];
  logic [CAddrWidth-1:0] lv_c [TreeDepth];
  logic [TreeDepth-1:0]  lv_n [TreeDepth];
  logic [W-1:0]          lv_x [TreeDepth];

  logic                  valid_q [TreeDepth-1];
  logic [CAddrWidth-1:0] c_q     [TreeDepth-1];
  logic [TreeDepth-1:0]  node_q  [TreeDepth-1];

  assign lv_v[0] = valid_i;
  assign lv_c[0] = cnt_q;
  assign lv_n[0] = '0;
  assign lv_x[0] = data_i[W-1:0];

  for (genvar l = 1; l < TreeDepth; l++) begin : g_lvl
    // Slice l is delayed l cycles so it meets its sample at level l.
    logic [W-1:0] dly_q [l];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < l; i++) begin
          dly_q[i] <= '0;
        end
      end else begin
        dly_q[0] <= data_i[l*W +: W];
        for (int i = 1; i < l; i++) begin
          dly_q[i] <= dly_q[i-1];
        end
      end
    end

    assign lv_v[l] = valid_q[l-1];
    assign lv_c[l] = c_q[l-1];
    assign lv_n[l] = node_q[l-1];
    assign lv_x[l] = dly_q[l-1];
  end

  // ---------------------------------------------------------------------------
  // Decisions and next node. nxt is taken modulo K: exact for inner levels, and
  // at the last level leaf - (K-1) == (leaf mod K) + 1, which gives k directly.
  // ---------------------------------------------------------------------------
  logic [TreeDepth-1:0] go_r;
  logic [TreeDepth-1:0] nxt [TreeDepth];

  always_comb begin
    go_r = '0;
    for (int l = 0; l < TreeDepth; l++) begin
      go_r[l] = fp_gt(lv_x[l], thr_q[lv_c[l]][lv_n[l]]);
      nxt[l]  = {lv_n[l][TreeDepth-2:0], 1'b0} + TreeDepth'(1) + TreeDepth'(go_r[l]);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline and output registers
  // ---------------------------------------------------------------------------
  logic                  valid_out_q;
  logic [CAddrWidth-1:0] c_out_q;
  logic [TreeDepth-1:0]  k_out_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      for (int l = 0; l < TreeDepth - 1; l++) begin
        valid_q[l] <= 1'b0;
        c_q[l]     <= '0;
        node_q[l]  <= '0;
      end
      valid_out_q <= 1'b0;
      c_out_q     <= '0;
      k_out_q     <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int l = 0; l < TreeDepth - 1; l++) begin
        valid_q[l] <= lv_v[l];
        c_q[l]     <= lv_c[l];
        node_q[l]  <= nxt[l];
      end
      valid_out_q <= lv_v[TreeDepth-1];
      // Address outputs hold their last valid values across bubbles.
      if (lv_v[TreeDepth-1]) begin
        c_out_q <= lv_c[TreeDepth-1];
        k_out_q <= nxt[TreeDepth-1] + 1'b1;
      end
    end
  end

  assign valid_o  = valid_out_q;
  assign c_addr_o = c_out_q;
  assign k_addr_o = k_out_q;

endmodule
